// File: rtl/alu_decode_pkg.sv
// Shared definitions for the ALU decode stage and the ALU: field offsets,
// op encodings, write-enable and read-mask constants.
package alu_decode_pkg;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SHL = 3'd5;
  localparam logic [2:0] OP_SHR = 3'd6;
  localparam logic [2:0] OP_MUL = 3'd7;

  localparam logic [1:0] WR_NONE = 2'b00;
  localparam logic [1:0] WR_Y1   = 2'b01;
  localparam logic [1:0] WR_Y2   = 2'b10;
  localparam logic [1:0] WR_BOTH = 2'b11;

  // Read-enable mask bit per operand select: bit0=a, bit1=b, bit2=c, bit3=d.
  localparam logic [3:0] RD_A = 4'b0001;
  localparam logic [3:0] RD_B = 4'b0010;
  localparam logic [3:0] RD_C = 4'b0100;
  localparam logic [3:0] RD_D = 4'b1000;

  function automatic int off_const_hi(input int sel_w);
    return 4 * sel_w;
  endfunction

  function automatic int off_reserved(input int sel_w);
    return 4 * sel_w + 4;
  endfunction

  function automatic int off_vec_perci(input int sel_w);
    return 4 * sel_w + 6;
  endfunction

  function automatic int off_form(input int sel_w);
    return 4 * sel_w + 8;
  endfunction

  function automatic int off_op(input int sel_w);
    return 4 * sel_w + 9;
  endfunction

  function automatic int off_const_c(input int sel_w);
    return 4 * sel_w + 12;
  endfunction

  function automatic int min_instr_w(input int sel_w);
    return 4 * sel_w + 13;
  endfunction

endpackage

// File: rtl/alu_decode_stage_scoreboard.sv
// Register write-pending scoreboard: set on issue, clear on writeback (set
// wins), register 0 never pending; combinational hazard lookup.
module alu_scoreboard
  import alu_decode_pkg::*;
#(
  parameter int SEL_W = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [1:0]                    set_en,
  input  logic [1:0][SEL_W-1:0]         set_sel,
  input  logic [1:0]                    clr_en,
  input  logic [1:0][SEL_W-1:0]         clr_sel,
  input  logic [3:0]                    rd_en,
  input  logic [3:0][SEL_W-1:0]         rd_sel,
  input  logic [1:0]                    wr_en,
  input  logic [1:0][SEL_W-1:0]         wr_sel,
  output logic [(2**SEL_W)-1:0]         pending,
  output logic                          hazard
);

  logic [(2**SEL_W)-1:0] set_mask;
  logic [(2**SEL_W)-1:0] clr_mask;
  logic [(2**SEL_W)-1:0] pending_nxt;

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    for (int i = 0; i < 2; i++) begin
      if (set_en[i]) set_mask[set_sel[i]] = 1'b1;
      if (clr_en[i]) clr_mask[clr_sel[i]] = 1'b1;
    end
    pending_nxt    = (pending & ~clr_mask) | set_mask;
    pending_nxt[0] = 1'b0;
  end

  // Lookup uses the registered vector only; a writeback unblocks next cycle.
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (rd_en[i] && pending[rd_sel[i]]) hazard = 1'b1;
    end
    for (int i = 0; i < 2; i++) begin
      if (wr_en[i] && pending[wr_sel[i]]) hazard = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pending <= '0;
    else       pending <= pending_nxt;
  end

endmodule

// File: rtl/alu_decode_stage.sv
// Registered ALU instruction decode stage with a one-entry output register,
// register scoreboard for RAW/WAW hazards, sticky invalid flag and stall count.
module alu_decode_stage
  import alu_decode_pkg::*;
#(
  parameter int SEL_W   = 4,
  parameter int INSTR_W = 32,
  parameter int CNT_W   = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [INSTR_W-1:0]       in_instr,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [2:0]               out_op,
  output logic [1:0]               out_vec_perci,
  output logic                     out_form,
  output logic                     out_const_c,
  output logic [4+3*SEL_W-1:0]     out_constant,
  output logic [SEL_W-1:0]         out_a_sel,
  output logic [SEL_W-1:0]         out_b_sel,
  output logic [SEL_W-1:0]         out_c_sel,
  output logic [SEL_W-1:0]         out_d_sel,
  output logic [SEL_W-1:0]         out_y1_sel,
  output logic [SEL_W-1:0]         out_y2_sel,
  output logic [1:0]               out_write,
  output logic                     out_invalid,
  input  logic                     wb0_valid,
  input  logic [SEL_W-1:0]         wb0_sel,
  input  logic                     wb1_valid,
  input  logic [SEL_W-1:0]         wb1_sel,
  output logic [(2**SEL_W)-1:0]    pending,
  output logic                     invalid_seen,
  output logic [CNT_W-1:0]         stall_count
);

  localparam int S      = SEL_W;
  localparam int CW     = 4 + 3 * SEL_W;
  localparam int P_CHI  = off_const_hi(SEL_W);
  localparam int P_RES  = off_reserved(SEL_W);
  localparam int P_VP   = off_vec_perci(SEL_W);
  localparam int P_FORM = off_form(SEL_W);
  localparam int P_OP   = off_op(SEL_W);
  localparam int P_CC   = off_const_c(SEL_W);
  localparam int MIN_W  = min_instr_w(SEL_W);
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  // Handshakes: a transfer happens on a rising edge where valid & ready are
  // both high; valid never depends on ready, and payload holds while valid
  // is high and ready is low.

  logic [S-1:0]  f_a, f_b, f_c, f_d;
  logic [3:0]    f_chi;
  logic [1:0]    f_res, f_vp;
  logic          f_form, f_cc, f_res_hi;
  logic [2:0]    f_op;

  assign f_d      = in_instr[S-1:0];
  assign f_c      = in_instr[2*S-1:S];
  assign f_b      = in_instr[3*S-1:2*S];
  assign f_a      = in_instr[4*S-1:3*S];
  assign f_chi    = in_instr[P_CHI +: 4];
  assign f_res    = in_instr[P_RES +: 2];
  assign f_vp     = in_instr[P_VP +: 2];
  assign f_form   = in_instr[P_FORM];
  assign f_op     = in_instr[P_OP +: 3];
  assign f_cc     = in_instr[P_CC];
  assign f_res_hi = |(in_instr >> MIN_W);

  logic [S-1:0]  d_y2;
  logic [1:0]    d_wr;
  logic [3:0]    d_rd;
  logic [CW-1:0] d_const;
  logic          d_inv;

  always_comb begin
    d_y2    = '0;
    d_wr    = WR_NONE;
    d_rd    = '0;
    d_const = '0;
    case ({f_form, f_cc})
      2'b01: begin
        d_wr    = WR_Y1;
        d_const = {f_chi, in_instr[3*S-1:0]};
        d_rd    = RD_B | RD_D;
      end
      2'b00: begin
        d_y2 = f_c;
        d_wr = {f_c != '0, f_a != '0};
        d_rd = RD_B | RD_C | RD_D;
      end
      2'b10: begin
        d_y2 = f_b;
        d_wr = {f_b != '0, f_a != '0};
        d_rd = RD_C | RD_D;
      end
      default: ;
    endcase
    d_inv = (f_form & f_cc) | (|f_res) | f_res_hi |
            ((d_wr == WR_BOTH) && (f_a == d_y2));
    // Malformed words still issue, but touch no registers.
    if (d_inv) begin
      d_wr    = WR_NONE;
      d_const = '0;
      d_rd    = '0;
    end
  end

  logic       full;
  logic [3:0] r_rd;
  logic       hazard;
  logic       issue;
  logic       accept;

  assign out_valid  = full & ~hazard;
  assign issue      = out_valid & out_ready;
  assign in_ready   = ~full | issue;
  assign accept     = in_valid & in_ready;
  assign out_y1_sel = out_a_sel;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      full          <= 1'b0;
      out_op        <= '0;
      out_vec_perci <= '0;
      out_form      <= 1'b0;
      out_const_c   <= 1'b0;
      out_constant  <= '0;
      out_a_sel     <= '0;
      out_b_sel     <= '0;
      out_c_sel     <= '0;
      out_d_sel     <= '0;
      out_y2_sel    <= '0;
      out_write     <= '0;
      out_invalid   <= 1'b0;
      r_rd          <= '0;
    end else if (flush) begin
      full <= 1'b0;
    end else if (accept) begin
      full          <= 1'b1;
      out_op        <= f_op;
      out_vec_perci <= f_vp;
      out_form      <= f_form;
      out_const_c   <= f_cc;
      out_constant  <= d_const;
      out_a_sel     <= f_a;
      out_b_sel     <= f_b;
      out_c_sel     <= f_c;
      out_d_sel     <= f_d;
      out_y2_sel    <= d_y2;
      out_write     <= d_wr;
      out_invalid   <= d_inv;
      r_rd          <= d_rd;
    end else if (issue) begin
      full <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      invalid_seen <= 1'b0;
      stall_count  <= '0;
    end else begin
      if (issue && out_invalid) invalid_seen <= 1'b1;
      if (full && hazard && !(&stall_count)) stall_count <= stall_count + CNT_ONE;
    end
  end

  alu_scoreboard #(.SEL_W(SEL_W)) u_scoreboard (
    .clk     (clk),
    .reset   (reset),
    .set_en  (issue ? out_write : WR_NONE),
    .set_sel ({out_y2_sel, out_a_sel}),
    .clr_en  ({wb1_valid, wb0_valid}),
    .clr_sel ({wb1_sel, wb0_sel}),
    .rd_en   (full ? r_rd : 4'b0000),
    .rd_sel  ({out_d_sel, out_c_sel, out_b_sel, out_a_sel}),
    .wr_en   (full ? out_write : WR_NONE),
    .wr_sel  ({out_y2_sel, out_a_sel}),
    .pending (pending),
    .hazard  (hazard)
  );

endmodule

// File: tb/tb_alu_decode_stage.sv
// Directed bench for alu_decode_stage (SEL_W=4, INSTR_W=32, CNT_W=16).
module tb_alu_decode_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [31:0] in_instr;
  logic        flush;
  logic        out_valid, out_ready;
  logic [2:0]  out_op;
  logic [1:0]  out_vec_perci;
  logic        out_form, out_const_c;
  logic [15:0] out_constant;
  logic [3:0]  out_a_sel, out_b_sel, out_c_sel, out_d_sel, out_y1_sel, out_y2_sel;
  logic [1:0]  out_write;
  logic        out_invalid;
  logic        wb0_valid, wb1_valid;
  logic [3:0]  wb0_sel, wb1_sel;
  logic [15:0] pending;
  logic        invalid_seen;
  logic [15:0] stall_count;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  alu_decode_stage #(.SEL_W(4), .INSTR_W(32), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_op(out_op), .out_vec_perci(out_vec_perci), .out_form(out_form),
    .out_const_c(out_const_c), .out_constant(out_constant),
    .out_a_sel(out_a_sel), .out_b_sel(out_b_sel), .out_c_sel(out_c_sel),
    .out_d_sel(out_d_sel), .out_y1_sel(out_y1_sel), .out_y2_sel(out_y2_sel),
    .out_write(out_write), .out_invalid(out_invalid),
    .wb0_valid(wb0_valid), .wb0_sel(wb0_sel), .wb1_valid(wb1_valid), .wb1_sel(wb1_sel),
    .pending(pending), .invalid_seen(invalid_seen), .stall_count(stall_count)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mk(input logic [2:0] op, input logic cc, input logic fm,
                                     input logic [1:0] vp, input logic [1:0] rs,
                                     input logic [3:0] chi, input logic [3:0] a,
                                     input logic [3:0] b, input logic [3:0] c,
                                     input logic [3:0] d);
    return {3'b000, cc, op, fm, vp, rs, chi, a, b, c, d};
  endfunction

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_instr = '0; flush = 1'b0; out_ready = 1'b0;
    wb0_valid = 1'b0; wb0_sel = '0; wb1_valid = 1'b0; wb1_sel = '0;
    step(); step();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_constant", out_constant, 0);
    chk("rst_write", out_write, 0);
    chk("rst_y2", out_y2_sel, 0);
    chk("rst_invalid", out_invalid, 0);
    chk("rst_pending", pending, 0);
    chk("rst_invalid_seen", invalid_seen, 0);
    chk("rst_stall", stall_count, 0);
    reset = 1'b0;
    step();

    // Constant form: a=3, const_hi=A, low=123.
    out_ready = 1'b1;
    in_valid = 1'b1; in_instr = mk(3'd2, 1, 0, 2'd1, 0, 4'hA, 4'd3, 4'd1, 4'd2, 4'd3);
    step();
    in_valid = 1'b0;
    chk("c_valid", out_valid, 1);
    chk("c_constant", out_constant, 16'hA123);
    chk("c_y1", out_y1_sel, 3);
    chk("c_y2", out_y2_sel, 0);
    chk("c_write", out_write, 2'b01);
    chk("c_op", out_op, 2);
    chk("c_vp", out_vec_perci, 1);
    step();
    chk("c_pending", pending, 16'h0008);
    chk("c_empty", out_valid, 0);
    wb0_valid = 1'b1; wb0_sel = 4'd3;
    step();
    wb0_valid = 1'b0;
    chk("c_wb_clear", pending, 0);

    // form=1: a=2, b=5 writes both; then a reader of 5 stalls.
    in_valid = 1'b1; in_instr = mk(3'd1, 0, 1, 0, 0, 0, 4'd2, 4'd5, 4'd0, 4'd0);
    step();
    chk("f1_write", out_write, 2'b11);
    chk("f1_y2", out_y2_sel, 5);
    in_instr = mk(3'd0, 1, 0, 0, 0, 0, 4'd7, 4'd5, 4'd0, 4'd1);
    step();
    in_valid = 1'b0;
    chk("f1_pending", pending, 16'h0024);
    chk("stall_valid0", out_valid, 0);
    chk("stall_cnt0", stall_count, 0);
    chk("stall_in_ready", in_ready, 0);
    step();
    chk("stall_cnt1", stall_count, 1);
    chk("stall_valid1", out_valid, 0);
    step();
    chk("stall_cnt2", stall_count, 2);
    wb1_valid = 1'b1; wb1_sel = 4'd5;
    chk("stall_no_bypass", out_valid, 0);
    step();
    wb1_valid = 1'b0;
    chk("unstall_valid", out_valid, 1);
    chk("stall_cnt3", stall_count, 3);
    step();
    chk("unstall_pending", pending, 16'h0084);
    chk("stall_cnt_hold", stall_count, 3);
    wb0_valid = 1'b1; wb0_sel = 4'd2; wb1_valid = 1'b1; wb1_sel = 4'd7;
    step();
    wb0_valid = 1'b0; wb1_valid = 1'b0;
    chk("f1_clear", pending, 0);

    // Three malformed words back to back.
    in_valid = 1'b1; in_instr = mk(3'd0, 1, 1, 0, 0, 0, 4'd1, 4'd2, 4'd0, 4'd0);
    step();
    chk("inv1_flag", out_invalid, 1);
    chk("inv1_write", out_write, 0);
    chk("inv1_valid", out_valid, 1);
    chk("inv1_seen_pre", invalid_seen, 0);
    in_instr = mk(3'd0, 1, 0, 0, 2'b01, 4'h5, 4'd1, 4'd2, 4'd3, 4'd4);
    step();
    chk("inv_seen", invalid_seen, 1);
    chk("inv2_flag", out_invalid, 1);
    chk("inv2_write", out_write, 0);
    chk("inv2_constant", out_constant, 0);
    in_instr = mk(3'd0, 0, 0, 0, 0, 0, 4'd4, 4'd1, 4'd4, 4'd2);
    step();
    in_valid = 1'b0;
    chk("inv3_flag", out_invalid, 1);
    chk("inv3_write", out_write, 0);
    step();
    chk("inv_no_pending", pending, 0);
    chk("inv_seen_sticky", invalid_seen, 1);

    // Stream of 8 independent constant-form instructions.
    in_valid = 1'b1; in_instr = mk(3'd0, 1, 0, 0, 0, 4'd0, 4'd1, 4'd0, 4'd0, 4'd0);
    for (int i = 0; i < 8; i++) begin
      chk("stream_in_ready", in_ready, 1);
      step();
      chk("stream_valid", out_valid, 1);
      chk("stream_y1", out_y1_sel, i + 1);
      chk("stream_const", out_constant, (i << 12) | (i << 4));
      if (i < 7)
        in_instr = mk(3'd0, 1, 0, 0, 0, 4'(i + 1), 4'(i + 2), 4'd0, 4'(i + 1), 4'd0);
      else
        in_valid = 1'b0;
    end
    step();
    chk("stream_drained", out_valid, 0);
    chk("stream_pending", pending, 16'h01FE);
    for (int i = 0; i < 4; i++) begin
      wb0_valid = 1'b1; wb0_sel = 4'(2 * i + 1);
      wb1_valid = 1'b1; wb1_sel = 4'(2 * i + 2);
      step();
    end
    wb0_valid = 1'b0; wb1_valid = 1'b0;
    chk("stream_clear", pending, 0);

    // Set beats clear on reg 6; destination 0 never pends.
    in_valid = 1'b1; in_instr = mk(3'd0, 1, 0, 0, 0, 0, 4'd6, 4'd0, 4'd0, 4'd0);
    step();
    in_valid = 1'b0;
    wb0_valid = 1'b1; wb0_sel = 4'd6;
    step();
    wb0_valid = 1'b0;
    chk("set_wins", pending, 16'h0040);
    in_valid = 1'b1; in_instr = mk(3'd0, 1, 0, 0, 0, 0, 4'd0, 4'd0, 4'd0, 4'd0);
    step();
    in_valid = 1'b0;
    chk("r0_write", out_write, 2'b01);
    chk("r0_y1", out_y1_sel, 0);
    step();
    chk("r0_no_pending", pending, 16'h0040);
    wb1_valid = 1'b1; wb1_sel = 4'd6;
    step();
    wb1_valid = 1'b0;
    chk("r6_clear", pending, 0);

    // Flush beats a same-cycle accept.
    in_valid = 1'b1; flush = 1'b1; in_instr = mk(3'd0, 1, 0, 0, 0, 0, 4'd8, 4'd0, 4'd0, 4'd0);
    step();
    in_valid = 1'b0; flush = 1'b0;
    chk("flush_accept_valid", out_valid, 0);
    chk("flush_accept_ready", in_ready, 1);
    chk("flush_accept_pend", pending, 0);

    // Flush and reset while stalled on reg 9.
    in_valid = 1'b1; in_instr = mk(3'd0, 1, 0, 0, 0, 0, 4'd9, 4'd0, 4'd0, 4'd0);
    step();
    in_instr = mk(3'd0, 1, 0, 0, 0, 0, 4'd10, 4'd9, 4'd0, 4'd0);
    step();
    in_valid = 1'b0;
    chk("fl_stalled", out_valid, 0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("fl_empty", out_valid, 0);
    chk("fl_in_ready", in_ready, 1);
    chk("fl_pending_kept", pending, 16'h0200);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("rs_stalled", out_valid, 0);
    chk("rs_in_ready_low", in_ready, 0);
    reset = 1'b1;
    #1;
    chk("rs_pending", pending, 0);
    chk("rs_valid", out_valid, 0);
    chk("rs_in_ready", in_ready, 1);
    chk("rs_stall", stall_count, 0);
    chk("rs_seen", invalid_seen, 0);
    chk("rs_write", out_write, 0);
    step();
    reset = 1'b0;
    step();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/alu_decode_stage.md
# alu_decode_stage

Registered, parametrised ALU instruction decode stage with valid/ready handshakes on both sides and a register scoreboard. It sits between the fetch queue and the ALU issue port. It decodes one instruction per cycle into operand selects, write enables and an immediate constant, and flags malformed encodings. It holds an instruction back while any source or destination register has a write outstanding, and clears pending writes from two writeback ports.

## Interface
Parameters:
- SEL_W, 4, register-select width; register file has 2**SEL_W entries, register 0 is hardwired zero.
- INSTR_W, 32, instruction width; must be >= 4*SEL_W+13.
- CNT_W, 16, width of the stall counter.

Ports:
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high.
- in_valid / in_ready  in / out  1 / 1  instruction handshake.
- in_instr  in  INSTR_W  instruction word.
- flush  in  1  synchronous; empties the output stage.
- out_valid / out_ready  out / in  1 / 1  issue handshake.
- out_op  out  3  ALU operation.
- out_vec_perci  out  2  vector/per-carry mode.
- out_form  out  1  instruction form.
- out_const_c  out  1  constant-operand flag.
- out_constant  out  4+3*SEL_W  immediate, zero when const_c=0.
- out_a_sel, out_b_sel, out_c_sel, out_d_sel  out  SEL_W each  operand selects.
- out_y1_sel, out_y2_sel  out  SEL_W each  result destinations.
- out_write  out  2  write enables for Y1 (bit 0) and Y2 (bit 1).
- out_invalid  out  1  malformed encoding.
- wb0_valid, wb1_valid  in  1 each  writeback completion strobes.
- wb0_sel, wb1_sel  in  SEL_W each  completing registers.
- pending  out  2**SEL_W  scoreboard bit vector.
- invalid_seen  out  1  sticky; set when an invalid instruction issues.
- stall_count  out  CNT_W  count of hazard-stall cycles, saturating.

## Operation
- Field layout, with S=SEL_W and B=4S:
  - d=[S-1:0], c=[2S-1:S], b=[3S-1:2S], a=[B-1:3S].
  - const_hi=[B+3:B], reserved=[B+5:B+4], vec_perci=[B+7:B+6], form=[B+8], op=[B+11:B+9], const_c=[B+12].
  - Bits [INSTR_W-1:B+13] are reserved.
- Decode:
  - Y1=a in all valid forms.
  - form=0, const_c=1: Y2=0; write=01; constant={const_hi, instr[3S-1:0]}; reads b, d.
  - form=0, const_c=0: Y2=c; write[0]=(a!=0); write[1]=(c!=0); reads b, c, d.
  - form=1, const_c=0: Y2=b; write[0]=(a!=0); write[1]=(b!=0); reads c, d.
- The instruction is invalid when any of these holds:
  - form=1 and const_c=1;
  - any reserved bit is set;
  - both write bits are set and Y1==Y2.
- An invalid instruction forces out_write=00, constant=0 and no reads, and it still issues.
- Register 0 is never marked pending and is never a hazard.
- Hazard: the held instruction is valid, and a read register or a written destination (WAW) has its pending bit set.
- Issue: out_valid & out_ready. On issue, pending is set for each destination enabled in out_write.
- Writeback: wbN_valid clears pending[wbN_sel]. If a set and a clear hit the same register in one cycle, the set wins.
- invalid_seen is set on issue of an instruction with out_invalid=1. Only reset clears it.
- stall_count increments every cycle that the stage is full and a hazard is present, and saturates at all-ones.
- flush empties the stage, dropping any held instruction. flush does not alter pending, and flush beats a same-cycle accept.

## Timing
- Reset values:
  - in_ready=1 and out_valid=0.
  - Every decoded output is 0, including out_invalid, out_constant, out_write and out_y2_sel.
  - pending=0, invalid_seen=0 and stall_count=0.
- Latency is one cycle: an instruction accepted in cycle n is visible at the outputs in cycle n+1.
- in_ready = !full | issue, which gives back-to-back throughput of one instruction per cycle.
- out_valid = full & !hazard. Outputs are stable while out_valid=1 and out_ready=0.
- Hazard uses registered pending, with no writeback bypass. A writeback in cycle n allows issue in cycle n+1 at the earliest.
- An asynchronous reset mid-stall drops the held instruction and clears the scoreboard immediately.

## Structure
- Package alu_decode_pkg holds the following; the stage and the ALU import it:
  - field-offset functions of SEL_W;
  - the op encoding constants;
  - the write-enable constants.
- Sub-module alu_scoreboard holds the pending vector, the set/clear priority and the hazard lookup for up to four read selects and two write selects.

## Test plan
- Reset, then accept form=0 const_c=1 with a=3, const_hi=0xA, low=0x123 -> next cycle: out_constant=0xA123, y1=3, y2=0, write=01, pending[3]=1 after issue.
- Issue form=1 with a=2, b=5, then hold wb off, then present an instruction reading 5 -> out_valid=0, stall_count increments each cycle. Pulse wb1_sel=5 -> issue exactly one cycle later.
- Present form=1 const_c=1, then reserved bit [B+4]=1, then a=c=4 with form=0 -> out_invalid=1, write=00, invalid_seen=1 after the first issue.
- Hold out_ready=1 and stream 8 independent instructions -> 8 issues in 8 consecutive cycles, in_ready constantly 1.
- In the same cycle, issue a write to reg 6 and pulse wb0_sel=6 -> pending[6]=1. A destination of 0 never sets pending.
- Assert flush while the stage is stalled, and also assert reset mid-stall -> stage empty, flush leaves pending intact, reset clears everything.
